// File: rtl/rotate_seq_pkg.sv
// rotate_seq_pkg: shared state encoding and helpers for the rotate sequencer
package rotate_seq_pkg;
  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
  function automatic int field_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  function automatic int rr_first(input logic [63:0] valid, input int ptr, input int n);
    int pick;
    int idx;
    logic found;
    pick = 0;
    found = 1'b0;
    for (int k = 0; k < n; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (!found && valid[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction
endpackage

// File: rtl/rotate_register_core.sv
// rotate_register_core: word register with priority load and rotate-left-by-one
module rotate_register_core #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // load wins over rotate; rotate moves the top bit into bit 0
  always_ff @(posedge clock or posedge reset)
    if (reset) q <= '0;
    else if (load) q <= d;
    else if (en) q <= {q[WIDTH-2:0], q[WIDTH-1]};
endmodule

// File: rtl/rotate_sequencer_arb.sv
// rotate_sequencer_arb: round-robin front end sharing one rotate datapath
module rotate_sequencer_arb
  import rotate_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  parameter int CNT_W = field_width(WIDTH),
  parameter int ID_W  = field_width(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*CNT_W-1:0] req_amount,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, amt_sel;
  logic [ID_W-1:0] ptr, winner;
  logic [WIDTH-1:0] data_sel;
  logic accept;
  assign winner    = ID_W'(rr_first(64'(req_valid), int'(ptr), NREQ));
  assign accept    = (state == IDLE) && (|req_valid);
  assign data_sel  = req_data[int'(winner)*WIDTH +: WIDTH];
  assign amt_sel   = req_amount[int'(winner)*CNT_W +: CNT_W];
  assign req_ready = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << winner) : '0;
  assign rsp_valid = state == DONE;
  assign busy      = state != IDLE;
  rotate_register_core #(.WIDTH(WIDTH)) u_core (
    .clock(clock),
    .reset(reset),
    .load(accept),
    .en(state == ROT),
    .d(data_sel),
    .q(rsp_data)
  );
  // state register; reset aborts any transaction in flight
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // zero amount skips ROT; the last rotate happens while the counter reads 1
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (accept ? ((amt_sel != '0) ? ROT : DONE) : IDLE) :
                (state == ROT)  ? ((cnt == CNT_W'(1)) ? DONE : ROT) :
                rsp_ready ? IDLE : DONE;
  end
  // capture transaction tag and amount at accept; advance the pointer past the served requester on completion
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt    <= '0;
      rsp_id <= '0;
      ptr    <= '0;
    end else begin
      if (accept) begin
        cnt    <= amt_sel;
        rsp_id <= winner;
      end else if (state == ROT) cnt <= cnt - 1'b1;
      if (state == DONE && rsp_ready) ptr <= (rsp_id == ID_W'(NREQ-1)) ? '0 : rsp_id + 1'b1;
    end
endmodule

// File: tb/tb_rotate_sequencer_arb.sv
// tb_rotate_sequencer_arb: randomized self-checking bench against a transaction-level model
`timescale 1ns/1ps
module tb_rotate_sequencer_arb;
  logic clock, reset, rsp_valid, rsp_ready, busy;
  logic [1:0] req_valid, req_ready;
  logic [15:0] req_data;
  logic [5:0] req_amount;
  logic [7:0] rsp_data;
  logic [0:0] rsp_id;
  int tests, fails, ptr_m;
  time acc_t, prev_t;

  rotate_sequencer_arb #(.WIDTH(8), .NREQ(2)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amount(req_amount), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rotl(input logic [7:0] d, input int a);
    logic [15:0] t;
    t = {d, d} << a;
    return t[15:8];
  endfunction

  task automatic do_txn(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [2:0] a0, input logic [2:0] a1, input int hold, input bit keep);
    int w, amt, k;
    logic [7:0] exp_d;
    w = -1;
    for (int i = 0; i < 2; i++) if (w < 0 && v[(ptr_m + i) % 2]) w = (ptr_m + i) % 2;
    amt = (w == 0) ? int'(a0) : int'(a1);
    exp_d = rotl((w == 0) ? d0 : d1, amt);
    req_valid = v;
    req_data = {d1, d0};
    req_amount = {a1, a0};
    #1;
    tests++; if (req_ready !== 2'(1 << w)) begin fails++; $display("FAIL grant: got %b want %b", req_ready, 2'(1 << w)); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
    @(posedge clock);
    prev_t = acc_t;
    acc_t = $time;
    #2;
    req_data = 16'($urandom);
    req_amount = 6'($urandom);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin
      tests++; if (req_ready !== 2'b00 || busy !== 1'b1) begin fails++; $display("FAIL rot_ready_busy: got ready %b busy %b want 00 1", req_ready, busy); end
      @(posedge clock);
      #2;
      k++;
    end
    tests++; if (k !== amt) begin fails++; $display("FAIL latency: got %0d extra cycles want %0d", k, amt); end
    repeat (hold) begin
      tests++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== 1'(w) || req_ready !== 2'b00 || busy !== 1'b1) begin
        fails++; $display("FAIL stall: got v %b d %h id %0d rdy %b busy %b want 1 %h %0d 00 1", rsp_valid, rsp_data, rsp_id, req_ready, busy, exp_d, w);
      end
      @(posedge clock);
      #2;
    end
    rsp_ready = 1'b1;
    #1;
    tests++; if (rsp_valid !== 1'b1 || req_ready !== 2'b00) begin fails++; $display("FAIL done_hs: got v %b rdy %b want 1 00", rsp_valid, req_ready); end
    tests++; if (rsp_data !== exp_d) begin fails++; $display("FAIL rsp_data: got %h want %h", rsp_data, exp_d); end
    tests++; if (rsp_id !== 1'(w)) begin fails++; $display("FAIL rsp_id: got %0d want %0d", rsp_id, w); end
    @(posedge clock);
    #2;
    ptr_m = (w + 1) % 2;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL return_idle: got v %b busy %b want 0 0", rsp_valid, busy); end
    if (!keep) begin
      rsp_ready = 1'b0;
      req_valid = 2'b00;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    req_data = '0;
    req_amount = '0;
    rsp_ready = 1'b0;
    ptr_m = 0;
    repeat (2) @(posedge clock);
    #2;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin fails++; $display("FAIL reset_ctrl: got v %b busy %b rdy %b want 0 0 00", rsp_valid, busy, req_ready); end
    tests++; if (rsp_data !== 8'h00 || rsp_id !== 1'b0) begin fails++; $display("FAIL reset_data: got %h id %0d want 00 0", rsp_data, rsp_id); end
    reset = 1'b0;
    @(posedge clock);
    #2;
  endtask

  task automatic test_basic();
    do_txn(2'b01, 8'h81, 8'h00, 3'd1, 3'd0, 0, 0);
    do_txn(2'b10, 8'h00, 8'hA5, 3'd0, 3'd0, 0, 0);
    do_txn(2'b11, 8'h01, 8'h55, 3'd7, 3'd3, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_txn(2'b11, 8'h3C + 8'(i), 8'hC1 ^ 8'(i), 3'd2, 3'd2, 0, 1);
      if (i > 0) begin
        tests++; if (acc_t - prev_t !== 40) begin fails++; $display("FAIL b2b_spacing: got %0t want 40", acc_t - prev_t); end
      end
    end
    rsp_ready = 1'b0;
    req_valid = 2'b00;
  endtask

  task automatic test_stall();
    do_txn(2'b11, 8'h96, 8'h4B, 3'd3, 3'd5, 5, 0);
  endtask

  task automatic test_reset_mid_rot();
    if (ptr_m != 1) do_txn(2'b01, 8'h11, 8'h22, 3'd1, 3'd1, 0, 0);
    req_valid = 2'b10;
    req_data = 16'hE700;
    req_amount = {3'd5, 3'd0};
    @(posedge clock);
    repeat (2) @(posedge clock);
    #2;
    req_valid = 2'b00;
    reset = 1'b1;
    #1;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin fails++; $display("FAIL abort: got v %b busy %b rdy %b want 0 0 00", rsp_valid, busy, req_ready); end
    @(posedge clock);
    #2;
    reset = 1'b0;
    ptr_m = 0;
    for (int i = 0; i < 10; i++) begin
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL no_rsp_after_abort: got %b want 0", rsp_valid); end
      @(posedge clock);
      #2;
    end
    do_txn(2'b11, 8'h5A, 8'hF0, 3'd4, 3'd2, 1, 0);
  endtask

  task automatic test_random();
    logic [1:0] v;
    for (int i = 0; i < 25; i++) begin
      v = 2'($urandom_range(1, 3));
      do_txn(v, 8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom), int'($urandom_range(0, 3)), 0);
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #2;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    acc_t = 0;
    prev_t = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid_rot();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
